// File: rtl/cache_axi_mem_responder.sv
//==============================================================================
// Module      : cache_axi_mem_responder
// Description : Word-array memory acting as the responder of the cache-side
//               simplified AXI burst bus. Serves single/burst word reads with
//               a configurable first-beat latency and burst writes with a
//               one-cycle write response. Flags protocol errors stickily.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cache_axi_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axi_ce_i,
    input  logic        axi_sel_i,
    input  logic        axi_ren_i,
    input  logic [31:0] axi_raddr_i,
    input  logic [3:0]  axi_rlen_i,
    input  logic        axi_rready_i,
    output logic [31:0] axi_rdata_o,
    output logic        axi_rvalid_o,
    input  logic        axi_wen_i,
    input  logic [31:0] axi_waddr_i,
    input  logic [3:0]  axi_wlen_i,
    input  logic [31:0] axi_wdata_i,
    input  logic        axi_wvalid_i,
    input  logic        axi_wlast_i,
    output logic        axi_bvalid_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_BURST = 3'd2,
        S_WR_BURST = 3'd3,
        S_WR_RESP  = 3'd4,
        S_TURN     = 3'd5
    } state_t;

    // Latency counter is preloaded with READ_LAT-1 so the first beat shows
    // up exactly READ_LAT edges after the acceptance edge.
    localparam logic [3:0]        c_lat_init = 4'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] c_idx_one  = ADDR_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_idx;
    logic [4:0]         r_cnt;
    logic [3:0]         r_wlen;
    logic [3:0]         r_lat;
    logic [31:0]        r_rdata;
    logic               r_rvalid;
    logic               r_bvalid;
    logic               r_err;
    logic [31:0]        r_mem [0:(2**ADDR_W)-1];

    logic [ADDR_W-1:0]  w_idx_inc;
    logic               w_wr_beat;
    logic               w_wr_at_len;
    logic               w_wr_final;
    logic               w_rd_last;
    logic               w_err_evt;
    logic               w_unused;

    // Index arithmetic wraps naturally at ADDR_W bits.
    assign w_idx_inc   = r_idx + c_idx_one;
    assign w_wr_beat   = (r_state == S_WR_BURST) && axi_wvalid_i;
    assign w_wr_at_len = (r_cnt[3:0] == r_wlen);
    assign w_wr_final  = w_wr_beat && (axi_wlast_i || w_wr_at_len);
    assign w_rd_last   = (r_state == S_RD_BURST) && axi_rready_i && (r_cnt == 5'd1);
    assign w_err_evt   = (w_wr_beat && (axi_wlast_i ^ w_wr_at_len))
                       || (axi_wvalid_i && (r_state != S_WR_BURST));

    // Select, byte-lane and aliased upper address bits carry no meaning here.
    assign w_unused = ^{axi_sel_i, axi_raddr_i[31:ADDR_W+2], axi_raddr_i[1:0],
                        axi_waddr_i[31:ADDR_W+2], axi_waddr_i[1:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic; read takes priority over a simultaneous write.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (axi_ce_i && axi_ren_i)      w_next = S_RD_WAIT;
                else if (axi_ce_i && axi_wen_i) w_next = S_WR_BURST;
            end
            S_RD_WAIT:  if (r_lat == 4'd0) w_next = S_RD_BURST;
            S_RD_BURST: if (w_rd_last)     w_next = S_TURN;
            S_WR_BURST: if (w_wr_final)    w_next = S_WR_RESP;
            S_WR_RESP:  w_next = S_TURN;
            S_TURN:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Burst bookkeeping, registered read data/valid, write response and error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx    <= '0;
            r_cnt    <= 5'd0;
            r_wlen   <= 4'd0;
            r_lat    <= 4'd0;
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
            r_bvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_bvalid <= w_wr_final;
            if (w_err_evt) r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (axi_ce_i && axi_ren_i) begin
                        r_idx <= axi_raddr_i[ADDR_W+1:2];
                        r_cnt <= {1'b0, axi_rlen_i} + 5'd1;
                        r_lat <= c_lat_init;
                    end else if (axi_ce_i && axi_wen_i) begin
                        r_idx  <= axi_waddr_i[ADDR_W+1:2];
                        r_cnt  <= 5'd0;
                        r_wlen <= axi_wlen_i;
                    end
                end
                S_RD_WAIT: begin
                    if (r_lat == 4'd0) begin
                        r_rdata  <= r_mem[r_idx];
                        r_rvalid <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end
                S_RD_BURST: begin
                    if (axi_rready_i) begin
                        if (r_cnt == 5'd1) begin
                            r_rvalid <= 1'b0;
                        end else begin
                            r_idx   <= w_idx_inc;
                            r_cnt   <= r_cnt - 5'd1;
                            r_rdata <= r_mem[w_idx_inc];
                        end
                    end
                end
                S_WR_BURST: begin
                    if (axi_wvalid_i) begin
                        r_idx <= w_idx_inc;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && w_wr_beat) r_mem[r_idx] <= axi_wdata_i;
    end

    assign axi_rdata_o  = r_rdata;
    assign axi_rvalid_o = r_rvalid;
    assign axi_bvalid_o = r_bvalid;
    assign err_o        = r_err;

endmodule

`default_nettype wire
